// File: rtl/conv_pkg.sv
// Shared widths, defaults and the requantiser model for the conv output stage.
// Macro CONV_OUT_RELU_EN selects unsigned ReLU clamping instead of signed saturation.
package conv_pkg;

    localparam int SUM_WIDTH      = 17;
    localparam int OUT_PIX_WIDTH  = 8;
    localparam int TREE_LAT_DEF   = 4;
    localparam int SHIFT_DEF      = 4;
    localparam int OUT_H_DEF      = 15;
    localparam int OUT_W_DEF      = 15;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef logic signed [SUM_WIDTH-1:0] sum_t;
    typedef logic        [OUT_PIX_WIDTH-1:0] pix_t;
    typedef logic signed [SUM_WIDTH:0]   acc_t;

    // Bias add, round-half-up, arithmetic shift, clamp to the pixel range
    function automatic pix_t requant(sum_t sum, sum_t bias);
        acc_t acc;
        acc_t r;
        acc_t hi;
        acc_t lo;
        acc = $signed({sum[SUM_WIDTH-1], sum}) + $signed({bias[SUM_WIDTH-1], bias});
        r   = (acc + acc_t'(2 ** (SHIFT_DEF - 1))) >>> SHIFT_DEF;
`ifdef CONV_OUT_RELU_EN
        hi = acc_t'((2 ** OUT_PIX_WIDTH) - 1);
        lo = '0;
`else
        hi = acc_t'((2 ** (OUT_PIX_WIDTH - 1)) - 1);
        lo = -acc_t'(2 ** (OUT_PIX_WIDTH - 1));
`endif
        if (r > hi) begin
            return hi[OUT_PIX_WIDTH-1:0];
        end
        if (r < lo) begin
            return lo[OUT_PIX_WIDTH-1:0];
        end
        return r[OUT_PIX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous first-word-fall-through FIFO for requantised pixels.
// A write while full is dropped and latches a sticky overflow flag.
module conv_out_fifo
    import conv_pkg::*;
#(
    parameter int WIDTH = OUT_PIX_WIDTH,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    // A read in the same clock frees the slot, so full+read+write is legal
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    // Entry storage; only ever read after being written, so no reset
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CW'(1);
            end
            if (wr_en && !do_wr) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_output_stage.sv
// Conv output stage: valid alignment, bias + requantise, credit-managed FIFO, pixel coordinates.
// Macro CONV_OUT_RELU_EN selects unsigned ReLU clamping instead of signed saturation.
module conv_output_stage
    import conv_pkg::*;
#(
    parameter int WIDTH        = SUM_WIDTH,
    parameter int OUT_WIDTH    = OUT_PIX_WIDTH,
    parameter int TREE_LATENCY = TREE_LAT_DEF,
    parameter int SHIFT        = SHIFT_DEF,
    parameter int OUT_H        = OUT_H_DEF,
    parameter int OUT_W        = OUT_W_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  sum_data,
    input  logic signed [WIDTH-1:0]  bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic [$clog2(OUT_H)-1:0] out_row,
    output logic [$clog2(OUT_W)-1:0] out_col,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     err_ovf
);

    localparam int RW     = $clog2(OUT_H);
    localparam int CW     = $clog2(OUT_W);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CRED_W = $clog2(FIFO_DEPTH + TREE_LATENCY + 2);

    typedef logic signed [WIDTH:0] wide_t;

    localparam wide_t RND = wide_t'(2 ** (SHIFT - 1));
`ifdef CONV_OUT_RELU_EN
    localparam wide_t HI = wide_t'((2 ** OUT_WIDTH) - 1);
    localparam wide_t LO = '0;
`else
    localparam wide_t HI = wide_t'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam wide_t LO = -wide_t'(2 ** (OUT_WIDTH - 1));
`endif

    logic [TREE_LATENCY-1:0] vdly;
    logic                    v_tap;
    wide_t                   acc;
    wide_t                   rnd;
    wide_t                   r_sh;
    logic [OUT_WIDTH-1:0]    q;
    logic                    rq_valid;
    logic [OUT_WIDTH-1:0]    rq_data;
    logic [OUT_WIDTH-1:0]    head;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [CNT_W-1:0]        fifo_count;
    logic [CRED_W-1:0]       inflight;
    logic [CRED_W-1:0]       credit;
    logic                    fire;
    logic [RW-1:0]           row;
    logic [CW-1:0]           col;
    logic                    end_col;
    logic                    end_row;

    assign v_tap = vdly[TREE_LATENCY-1];

    // Carry in_valid along so it reaches the tap together with its tree sum
    always_ff @(posedge clk) begin
        if (!reset) begin
            vdly <= '0;
        end else begin
            vdly <= (vdly << 1) | TREE_LATENCY'(in_valid);
        end
    end

    // Bias add in one extra bit, round half up, arithmetic shift, clamp
    always_comb begin
        acc  = $signed({sum_data[WIDTH-1], sum_data}) + $signed({bias[WIDTH-1], bias});
        rnd  = acc + RND;
        r_sh = rnd >>> SHIFT;
        q    = r_sh[OUT_WIDTH-1:0];
        if (r_sh > HI) begin
            q = HI[OUT_WIDTH-1:0];
        end else if (r_sh < LO) begin
            q = LO[OUT_WIDTH-1:0];
        end
    end

    // Requant register feeding the FIFO write port
    always_ff @(posedge clk) begin
        if (!reset) begin
            rq_valid <= 1'b0;
            rq_data  <= '0;
        end else begin
            rq_valid <= v_tap;
            if (v_tap) begin
                rq_data <= q;
            end
        end
    end

    conv_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rq_valid),
        .wr_data (rq_data),
        .rd_en   (fire),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count),
        .ovf     (err_ovf)
    );

    // Credit: every accepted pixel still in the pipe already owns a FIFO slot
    always_comb begin
        inflight = CRED_W'(rq_valid);
        for (int i = 0; i < TREE_LATENCY; i++) begin
            inflight = inflight + CRED_W'(vdly[i]);
        end
        credit = CRED_W'(fifo_count) + inflight;
    end

    assign in_ready  = ~fifo_full & (credit < CRED_W'(FIFO_DEPTH));
    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? '0 : head;
    assign fire      = out_valid & out_ready;

    assign end_col    = (col == CW'(OUT_W - 1));
    assign end_row    = (row == RW'(OUT_H - 1));
    assign out_row    = row;
    assign out_col    = col;
    assign out_last   = out_valid & end_col & end_row;
    assign frame_done = fire & out_last;

    // Raster coordinates of the FIFO head, advanced on each accepted pixel
    always_ff @(posedge clk) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (fire) begin
            if (end_col) begin
                col <= '0;
                row <= end_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_output_stage.sv
// Directed bench for conv_output_stage: latency, requant, credit, overflow, frame, reset.
// Expected pixels follow CONV_OUT_RELU_EN when the bench is built with it.
module tb_conv_output_stage;
    import conv_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [16:0] sum_data;
    logic signed [16:0] bias;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [3:0]        out_row;
    logic [3:0]        out_col;
    logic              out_last;
    logic              frame_done;
    logic              err_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [16:0] tree_in;
    logic signed [16:0] bias_in;
    logic signed [16:0] sum_pipe [4];
    logic signed [16:0] bias_pipe [4];

    logic [7:0] mq_data [$];
    logic [3:0] mq_row [$];
    logic [3:0] mq_col [$];
    logic       mq_last [$];
    logic       mq_fd [$];
    int         fd_count;

    always #5 clk = ~clk;

    conv_output_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum_data   (sum_data),
        .bias       (bias),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .frame_done (frame_done),
        .err_ovf    (err_ovf)
    );

    // Four-clock adder tree model: value given with in_valid appears 4 clocks later
    always @(posedge clk) begin
        sum_pipe[0]  <= tree_in;
        sum_pipe[1]  <= sum_pipe[0];
        sum_pipe[2]  <= sum_pipe[1];
        sum_pipe[3]  <= sum_pipe[2];
        bias_pipe[0] <= bias_in;
        bias_pipe[1] <= bias_pipe[0];
        bias_pipe[2] <= bias_pipe[1];
        bias_pipe[3] <= bias_pipe[2];
    end

    assign sum_data = sum_pipe[3];
    assign bias     = bias_pipe[3];

    // Record every accepted output pixel, sampled mid-cycle
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (frame_done) fd_count++;
            if (out_valid && out_ready) begin
                mq_data.push_back(out_data);
                mq_row.push_back(out_row);
                mq_col.push_back(out_col);
                mq_last.push_back(out_last);
                mq_fd.push_back(frame_done);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_q();
        mq_data.delete();
        mq_row.delete();
        mq_col.delete();
        mq_last.delete();
        mq_fd.delete();
        fd_count = 0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_q();
    endtask

    task automatic send(input logic signed [16:0] s, input logic signed [16:0] b, output bit ok);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        ok = in_ready;
        if (ok) begin
            in_valid = 1'b1;
            tree_in  = s;
            bias_in  = b;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_q(input int n, input int lim, output bit ok);
        int w = 0;
        while (mq_data.size() < n && w < lim) begin
            @(posedge clk); #1;
            w++;
        end
        ok = (mq_data.size() >= n);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tree_in   = '0;
        bias_in   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h want 00", out_data); end
        n_checks++; if (out_row !== 4'd0) begin n_fail++; $display("FAIL rst_row: got %0d want 0", out_row); end
        n_checks++; if (out_col !== 4'd0) begin n_fail++; $display("FAIL rst_col: got %0d want 0", out_col); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b want 0", out_last); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_err_ovf: got %b want 0", err_ovf); end
        @(posedge clk); #1;
        reset = 1'b1;
        clear_q();
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tree_in   = 17'sd100;
        bias_in   = 17'sd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: out_valid got %b want 0 at t+5", out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: out_valid got %b want 1 at t+6", out_valid); end
        n_checks++; if (out_data !== 8'd8) begin n_fail++; $display("FAIL lat_data: got %h want 08", out_data); end
        n_checks++; if ({out_row, out_col} !== 8'h00) begin n_fail++; $display("FAIL lat_coord: got (%0d,%0d) want (0,0)", out_row, out_col); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL lat_last: got %b want 0", out_last); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_requant();
        int         vs [13];
        int         vb [13];
        logic [7:0] ex [13];
        bit         ok;
        bit         all_ok;
        vs = '{100, -50, 65535, -65536, 8, 7, -9, 1000, 2040, 2039, 4088, -2057, -2048};
        vb = '{20, 10, 0, 0, 0, 0, 0, -24, 0, 0, 0, 0, 0};
`ifdef CONV_OUT_RELU_EN
        ex = '{8'h08, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h3D, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h00};
`else
        ex = '{8'h08, 8'hFE, 8'h7F, 8'h80, 8'h01, 8'h00, 8'hFF, 8'h3D, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80};
`endif
        do_reset();
        out_ready = 1'b1;
        all_ok = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send(17'(vs[i]), 17'(vb[i]), ok);
            all_ok &= ok;
        end
        wait_q(13, 60, ok);
        all_ok &= ok;
        n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL rq_timeout: got %0d pixels want 13", mq_data.size()); end
        for (int i = 0; i < 13 && i < mq_data.size(); i++) begin
            n_checks++;
            if (mq_data[i] !== ex[i] || mq_col[i] !== 4'(i)) begin
                n_fail++;
                $display("FAIL rq_vec%0d: got data %h col %0d want data %h col %0d", i, mq_data[i], mq_col[i], ex[i], i);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc_n = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            if (in_ready) begin
                in_valid = 1'b1;
                tree_in  = 17'(16 * (acc_n + 1));
                bias_in  = '0;
                acc_n++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++; if (acc_n != 8) begin n_fail++; $display("FAIL bp_accepted: got %0d want 8", acc_n); end
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL bp_err_ovf: got %b want 0", err_ovf); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd1) begin n_fail++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=01", out_valid, out_data); end
        @(negedge clk);
        n_checks++; if (out_data !== 8'd1 || {out_row, out_col} !== 8'h00) begin n_fail++; $display("FAIL bp_hold: got d=%h (%0d,%0d) want d=01 (0,0)", out_data, out_row, out_col); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(k) || out_col !== 4'(k - 1)) begin
                n_fail++;
                $display("FAIL bp_drain%0d: got v=%b d=%h col=%0d want v=1 d=%h col=%0d", k, out_valid, out_data, out_col, 8'(k), k - 1);
            end
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        bit ok;
        bit all_ok = 1'b1;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            send(17'(16 * k), '0, ok);
            all_ok &= ok;
        end
        repeat (8) @(posedge clk); #1;
        n_checks++; if (all_ok !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL ov_fill: got ok=%b rdy=%b want ok=1 rdy=0", all_ok, in_ready); end
        in_valid = 1'b1;
        tree_in  = 17'sd144;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ov_wr_rd_full: err_ovf got %b want 0", err_ovf); end
        n_checks++; if (out_data !== 8'd2) begin n_fail++; $display("FAIL ov_head: got %h want 02", out_data); end
        @(posedge clk); #1;
        in_valid = 1'b1;
        tree_in  = 17'sd160;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ov_sticky: err_ovf got %b want 1", err_ovf); end
        @(posedge clk); #1;
        clear_q();
        out_ready = 1'b1;
        wait_q(8, 30, ok);
        repeat (4) @(posedge clk); #1;
        n_checks++; if (ok !== 1'b1 || mq_data.size() != 8) begin n_fail++; $display("FAIL ov_drain_count: got %0d want 8", mq_data.size()); end
        for (int i = 0; i < 8 && i < mq_data.size(); i++) begin
            n_checks++;
            if (mq_data[i] !== 8'(i + 2)) begin n_fail++; $display("FAIL ov_drain%0d: got %h want %h", i, mq_data[i], 8'(i + 2)); end
        end
        n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ov_hold: err_ovf got %b want 1", err_ovf); end
        do_reset();
        @(negedge clk);
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ov_clear: err_ovf got %b want 0", err_ovf); end
    endtask

    task automatic test_frame();
        bit ok;
        bit all_ok = 1'b1;
        int lasts = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 225; i++) begin
            send(17'(16 * (i % 100)), '0, ok);
            all_ok &= ok;
        end
        wait_q(225, 100, ok);
        all_ok &= ok;
        n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL fr_timeout: got %0d pixels want 225", mq_data.size()); end
        if (mq_data.size() >= 225) begin
            n_checks++; if ({mq_row[14], mq_col[14]} !== {4'd0, 4'd14}) begin n_fail++; $display("FAIL fr_p14: got (%0d,%0d) want (0,14)", mq_row[14], mq_col[14]); end
            n_checks++; if ({mq_row[15], mq_col[15]} !== {4'd1, 4'd0}) begin n_fail++; $display("FAIL fr_p15: got (%0d,%0d) want (1,0)", mq_row[15], mq_col[15]); end
            n_checks++; if ({mq_row[223], mq_col[223], mq_last[223]} !== {4'd14, 4'd13, 1'b0}) begin n_fail++; $display("FAIL fr_p223: got (%0d,%0d) last=%b want (14,13) last=0", mq_row[223], mq_col[223], mq_last[223]); end
            n_checks++; if ({mq_row[224], mq_col[224], mq_last[224], mq_fd[224]} !== {4'd14, 4'd14, 1'b1, 1'b1}) begin n_fail++; $display("FAIL fr_p224: got (%0d,%0d) last=%b fd=%b want (14,14) last=1 fd=1", mq_row[224], mq_col[224], mq_last[224], mq_fd[224]); end
            for (int i = 0; i < 225; i++) lasts += int'(mq_last[i]);
            n_checks++; if (lasts != 1 || fd_count != 1) begin n_fail++; $display("FAIL fr_pulses: got last=%0d frame_done=%0d want 1 and 1", lasts, fd_count); end
        end
        send(17'sd32, '0, ok);
        wait_q(226, 20, ok);
        n_checks++;
        if (ok !== 1'b1 || {mq_row[225], mq_col[225], mq_last[225]} !== {4'd0, 4'd0, 1'b0} || mq_data[225] !== 8'd2) begin
            n_fail++;
            $display("FAIL fr_next: got ok=%b d=%h (%0d,%0d) want d=02 (0,0)", ok, mq_data[225], mq_row[225], mq_col[225]);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_flight();
        bit ok;
        bit all_ok = 1'b1;
        bit ghost = 1'b0;
        do_reset();
        send(17'sd16, '0, ok); all_ok &= ok;
        send(17'sd32, '0, ok); all_ok &= ok;
        repeat (6) @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd1) begin n_fail++; $display("FAIL rf_buffered: got v=%b d=%h want v=1 d=01", out_valid, out_data); end
        send(17'sd48, '0, ok); all_ok &= ok;
        send(17'sd64, '0, ok); all_ok &= ok;
        send(17'sd80, '0, ok); all_ok &= ok;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_q();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin n_fail++; $display("FAIL rf_cleared: got v=%b rdy=%b d=%h want v=0 rdy=1 d=00", out_valid, in_ready, out_data); end
        repeat (10) begin
            @(negedge clk);
            if (out_valid) ghost = 1'b1;
        end
        n_checks++; if (ghost !== 1'b0) begin n_fail++; $display("FAIL rf_ghost: got out_valid=1 want 0 after reset"); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(17'sd112, '0, ok); all_ok &= ok;
        wait_q(1, 20, ok);
        all_ok &= ok;
        n_checks++;
        if (all_ok !== 1'b1 || mq_data[0] !== 8'd7 || {mq_row[0], mq_col[0]} !== 8'h00) begin
            n_fail++;
            $display("FAIL rf_next: got ok=%b d=%h (%0d,%0d) want d=07 (0,0)", all_ok, mq_data[0], mq_row[0], mq_col[0]);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        fd_count = 0;
        test_reset();
        test_latency();
        test_requant();
        test_backpressure();
        test_overflow();
        test_frame();
        test_reset_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
